// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: datapath width and the adder arbiter state type.
package alu_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ADD, RESP} arb_state_t;
endpackage

// File: rtl/Add.sv
// Shared 32-bit adder datapath; carry-out is not produced.
module Add
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/add_share_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            any_valid
);
  // (p + k) mod NREQ without leaving the index width
  function automatic logic [ID_W-1:0] wrap(input logic [ID_W-1:0] p, input int k);
    logic [ID_W:0] s;
    s = {1'b0, p} + (ID_W+1)'(k);
    if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
    return s[ID_W-1:0];
  endfunction

  // scan farthest-to-nearest so the requester closest to ptr wins
  always_comb begin
    idx       = '0;
    any_valid = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap(ptr, k)]) idx = wrap(ptr, k);
    end
  end
endmodule

// File: rtl/add_share_arbiter.sv
// Time-shares one Add instance among NREQ requesters, one transaction in flight.
module add_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_sum,
  output logic [ID_W-1:0]        resp_id,
  input  logic [NREQ-1:0]        resp_ready
);
  arb_state_t state, state_nx;

  logic [NREQ-1:0][DATA_W-1:0] a_v, b_v;
  logic [DATA_W-1:0] op_a, op_b, sum_d, sum_q;
  logic [ID_W-1:0]   rr_ptr, id_q, rid_q, win;
  logic              any_valid, done;

  assign a_v = req_a;
  assign b_v = req_b;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .idx      (win),
    .any_valid(any_valid)
  );

  Add u_add (
    .a  (op_a),
    .b  (op_b),
    .sum(sum_d)
  );

  assign done = (state == RESP) && resp_ready[id_q];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: accept -> one add cycle -> hold response until owner takes it
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = ADD;
      ADD:     state_nx = RESP;
      RESP:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake outputs; req_ready is held low while reset is asserted
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state == IDLE && !rst && any_valid) req_ready[win] = 1'b1;
    if (state == RESP) resp_valid[id_q] = 1'b1;
  end

  // resp_id has its own register so it keeps the old owner while the next
  // transaction is in ADD; sum_q only moves at the ADD edge so it can drive directly
  assign resp_sum = sum_q;
  assign resp_id  = rid_q;

  // operand latch, result capture and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      id_q   <= '0;
      sum_q  <= '0;
      rid_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        op_a <= a_v[win];
        op_b <= b_v[win];
        id_q <= win;
      end
      if (state == ADD) begin
        sum_q <= sum_d;
        rid_q <= id_q;
      end
      if (done) rr_ptr <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
    end
  end
endmodule

// File: tb/tb_add_share_arbiter.sv
// Randomized + directed bench for add_share_arbiter (NREQ=4) with a
// transaction-level reference model and per-cycle output comparison.
module tb_add_share_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0, req_ready, resp_valid, resp_ready = 4'hF;
  logic [127:0] req_a = '0, req_b = '0;
  logic [31:0]  resp_sum;
  logic [1:0]   resp_id;

  int checks = 0;
  int errors = 0;

  add_share_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_sum(resp_sum),
    .resp_id(resp_id), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // first valid requester starting at p, going round the ring
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  // ph: 0 waiting for a winner, 1 sum being computed, 2 response offered
  int          ph = 0, m_id = 0, m_ptr = 0, last_id = 0;
  logic [31:0] m_sum = '0, last_sum = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; m_ptr <= 0; last_sum <= '0; last_id <= 0;
    end else begin
      case (ph)
        0: if (pick(req_valid, m_ptr) >= 0) begin
          m_id  <= pick(req_valid, m_ptr);
          m_sum <= req_a[32*pick(req_valid, m_ptr) +: 32] + req_b[32*pick(req_valid, m_ptr) +: 32];
          ph    <= 1;
        end
        1: begin ph <= 2; last_sum <= m_sum; last_id <= m_id; end
        default: if (resp_ready[m_id]) begin ph <= 0; m_ptr <= (m_id + 1) % 4; end
      endcase
    end
  end

  // compare every cycle, away from the rising edge
  always @(negedge clk) begin
    int w;
    logic [3:0] e_rr, e_rv;
    w    = pick(req_valid, m_ptr);
    e_rr = (ph == 0 && !rst && w >= 0) ? 4'(1 << w) : 4'h0;
    e_rv = (ph == 2) ? 4'(1 << m_id) : 4'h0;
    chk("model req_ready",  {28'b0, req_ready},  {28'b0, e_rr});
    chk("model resp_valid", {28'b0, resp_valid}, {28'b0, e_rv});
    chk("model resp_sum",   resp_sum, last_sum);
    chk("model resp_id",    {30'b0, resp_id}, 32'(last_id));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    #1;
  endtask

  // one transaction from requester i; operands are scrambled right after
  // the accept edge, and bp>0 withholds the owner's resp_ready for bp cycles
  task automatic txn(input int i, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int bp);
    bit ok = 0;
    logic [31:0] s0;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid = 4'(1 << i);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[i]) begin ok = 1; break; end
      step();
    end
    chk("accept seen", 32'(ok), 32'd1);
    if (!ok) begin req_valid = '0; return; end
    chk("req_ready one-hot", {28'b0, req_ready}, 32'(1 << i));
    step();
    req_valid = '0;
    req_a[32*i +: 32] = 32'd100;
    req_b[32*i +: 32] = 32'd200;
    #1 chk("no resp in ADD", {28'b0, resp_valid}, 32'd0);
    step();
    chk("resp_valid", {28'b0, resp_valid}, 32'(1 << i));
    chk("resp_sum", resp_sum, exp);
    chk("resp_id", {30'b0, resp_id}, 32'(i));
    if (bp > 0) begin
      s0 = resp_sum;
      resp_ready = ~4'(1 << i);
      req_valid  = 4'hF;
      for (int c = 0; c < bp; c++) begin
        step();
        chk("bp resp_valid", {28'b0, resp_valid}, 32'(1 << i));
        chk("bp resp_sum", resp_sum, s0);
        chk("bp resp_id", {30'b0, resp_id}, 32'(i));
        chk("bp req_ready", {28'b0, req_ready}, 32'd0);
      end
      req_valid = '0;
    end
    resp_ready = 4'hF;
    step();
    chk("done resp_valid", {28'b0, resp_valid}, 32'd0);
  endtask

  int grants[$];

  initial begin
    // reset state
    #3 chk("rst req_ready", {28'b0, req_ready}, 32'd0);
    chk("rst resp_valid", {28'b0, resp_valid}, 32'd0);
    chk("rst resp_sum", resp_sum, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // basic add, wrap-around, operand isolation
    txn(0, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 0);
    txn(1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    txn(3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0);
    txn(1, 32'd3, 32'd4, 32'h0000_0007, 0);

    // backpressure with non-owner resp_ready high
    txn(2, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 5);

    // fairness: all requesters valid, ptr starts at 0
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      #1;
      for (int k = 0; k < 4; k++) if (req_ready[k]) grants.push_back(k);
      step();
    end
    req_valid = '0;
    chk("grant count", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      chk("grant0", 32'(grants[0]), 32'd0);
      chk("grant1", 32'(grants[1]), 32'd1);
      chk("grant2", 32'(grants[2]), 32'd2);
      chk("grant3", 32'(grants[3]), 32'd3);
      chk("grant4", 32'(grants[4]), 32'd0);
    end
    repeat (4) step();

    // after serving 2, req 2 and req 0 compete: 0 wins
    do_reset();
    txn(2, 32'd1, 32'd2, 32'd3, 0);
    req_valid = 4'b0101;
    #1 chk("rr after 2", {28'b0, req_ready}, 32'b0001);
    step();
    req_valid = '0;
    repeat (3) step();

    // reset during ADD with id=2
    req_a[64 +: 32] = 32'd50;
    req_b[64 +: 32] = 32'd60;
    req_valid = 4'b0100;
    #1 chk("pre-rst accept", {28'b0, req_ready}, 32'b0100);
    step();
    req_valid = '0;
    #2 rst = 1'b1;
    #1 chk("midrst req_ready", {28'b0, req_ready}, 32'd0);
    chk("midrst resp_valid", {28'b0, resp_valid}, 32'd0);
    chk("midrst resp_sum", resp_sum, 32'd0);
    chk("midrst resp_id", {30'b0, resp_id}, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("no stale resp", {28'b0, resp_valid}, 32'd0);
    txn(2, 32'd9, 32'd10, 32'd19, 0);

    // randomized traffic, model checks every cycle
    for (int c = 0; c < 400; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 15)) : 4'h0;
      for (int k = 0; k < 4; k++) begin
        req_a[32*k +: 32] = $urandom;
        req_b[32*k +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      step();
    end
    req_valid  = '0;
    resp_ready = 4'hF;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
